// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS decode/execute slice with main decode, ALU control and a 32-bit ALU.
// Latency is 1 cycle with no backpressure, and ALU_SHIFT_EN enables the sll/srl functs.
module mips_decode_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [1:0]  regdst,
  output logic        regwrite,
  output logic        branch,
  output logic        jump,
  output logic        memread,
  output logic [1:0]  memtoreg,
  output logic        memwrite,
  output logic [1:0]  aluop,
  output logic        alusrc,
  output logic [3:0]  aluctrl,
  output logic [31:0] alu_result,
  output logic        alu_zero
);

  logic [1:0]  regdst_c;
  logic        regwrite_c;
  logic        branch_c;
  logic        jump_c;
  logic        memread_c;
  logic [1:0]  memtoreg_c;
  logic        memwrite_c;
  logic [1:0]  aluop_c;
  logic        alusrc_c;
  logic [3:0]  aluctrl_c;
  logic [31:0] b_op;
  logic [31:0] result_c;

  always_comb begin
    regdst_c   = 2'b00;
    regwrite_c = 1'b0;
    branch_c   = 1'b0;
    jump_c     = 1'b0;
    memread_c  = 1'b0;
    memtoreg_c = 2'b00;
    memwrite_c = 1'b0;
    aluop_c    = 2'b00;
    alusrc_c   = 1'b0;
    case (instr[31:26])
      6'b000000: begin regdst_c = 2'b01; regwrite_c = 1'b1; aluop_c = 2'b10; end
      6'b100011: begin regwrite_c = 1'b1; memread_c = 1'b1; memtoreg_c = 2'b01; alusrc_c = 1'b1; end
      6'b101011: begin memwrite_c = 1'b1; alusrc_c = 1'b1; end
      6'b000100: begin branch_c = 1'b1; aluop_c = 2'b01; end
      6'b001000: begin regwrite_c = 1'b1; alusrc_c = 1'b1; end
      6'b001101: begin regwrite_c = 1'b1; aluop_c = 2'b11; alusrc_c = 1'b1; end
      6'b000010: jump_c = 1'b1;
      6'b000011: begin regdst_c = 2'b10; regwrite_c = 1'b1; jump_c = 1'b1; memtoreg_c = 2'b10; end
      default: ;
    endcase
  end

  always_comb begin
    aluctrl_c = 4'b1111;
    case (aluop_c)
      2'b00: aluctrl_c = 4'b0010;
      2'b01: aluctrl_c = 4'b0110;
      2'b11: aluctrl_c = 4'b0001;
      default: begin
        case (instr[5:0])
          6'b100000: aluctrl_c = 4'b0010;
          6'b100010: aluctrl_c = 4'b0110;
          6'b100100: aluctrl_c = 4'b0000;
          6'b100101: aluctrl_c = 4'b0001;
          6'b101010: aluctrl_c = 4'b0111;
          6'b100111: aluctrl_c = 4'b1100;
`ifdef ALU_SHIFT_EN
          6'b000000: aluctrl_c = 4'b1000;
          6'b000010: aluctrl_c = 4'b1001;
`endif
          default:   aluctrl_c = 4'b1111;
        endcase
      end
    endcase
  end

  // ori deliberately shares the sign-extended immediate path with lw/sw/addi.
  assign b_op = alusrc_c ? {{16{instr[15]}}, instr[15:0]} : rt_data;

  always_comb begin
    result_c = 32'd0;
    case (aluctrl_c)
      4'b0000: result_c = rs_data & b_op;
      4'b0001: result_c = rs_data | b_op;
      4'b0010: result_c = rs_data + b_op;
      4'b0110: result_c = rs_data - b_op;
      4'b1100: result_c = ~(rs_data | b_op);
      4'b0111: result_c = ($signed(rs_data) < $signed(b_op)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      4'b1000: result_c = b_op << instr[10:6];
      4'b1001: result_c = b_op >> instr[10:6];
`endif
      default: result_c = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regdst     <= 2'b00;
      regwrite   <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      memread    <= 1'b0;
      memtoreg   <= 2'b00;
      memwrite   <= 1'b0;
      aluop      <= 2'b00;
      alusrc     <= 1'b0;
      aluctrl    <= 4'b0000;
      alu_result <= 32'd0;
      alu_zero   <= 1'b0;
    end else begin
      regdst     <= regdst_c;
      regwrite   <= regwrite_c;
      branch     <= branch_c;
      jump       <= jump_c;
      memread    <= memread_c;
      memtoreg   <= memtoreg_c;
      memwrite   <= memwrite_c;
      aluop      <= aluop_c;
      alusrc     <= alusrc_c;
      aluctrl    <= aluctrl_c;
      alu_result <= result_c;
      alu_zero   <= (result_c == 32'd0);
    end
  end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed-vector bench for mips_decode_exec with hand-computed expectations.
module tb_mips_decode_exec;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [1:0]  regdst;
  logic        regwrite;
  logic        branch;
  logic        jump;
  logic        memread;
  logic [1:0]  memtoreg;
  logic        memwrite;
  logic [1:0]  aluop;
  logic        alusrc;
  logic [3:0]  aluctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  int errors = 0;
  int checks = 0;

  // {regdst, regwrite, branch, jump, memread, memtoreg, memwrite, aluop, alusrc}
  localparam logic [11:0] C_R    = 12'b01_1_0_0_0_00_0_10_0;
  localparam logic [11:0] C_LW   = 12'b00_1_0_0_1_01_0_00_1;
  localparam logic [11:0] C_SW   = 12'b00_0_0_0_0_00_1_00_1;
  localparam logic [11:0] C_BEQ  = 12'b00_0_1_0_0_00_0_01_0;
  localparam logic [11:0] C_ADDI = 12'b00_1_0_0_0_00_0_00_1;
  localparam logic [11:0] C_ORI  = 12'b00_1_0_0_0_00_0_11_1;
  localparam logic [11:0] C_J    = 12'b00_0_0_1_0_00_0_00_0;
  localparam logic [11:0] C_JAL  = 12'b10_1_0_1_0_10_0_00_0;
  localparam logic [11:0] C_NOP  = 12'b00_0_0_0_0_00_0_00_0;

  mips_decode_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .branch     (branch),
    .jump       (jump),
    .memread    (memread),
    .memtoreg   (memtoreg),
    .memwrite   (memwrite),
    .aluop      (aluop),
    .alusrc     (alusrc),
    .aluctrl    (aluctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic rst_v, input logic [31:0] i,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [11:0] exp_ctrl, input logic [3:0] exp_aluctrl,
                     input logic [31:0] exp_res, input logic exp_zero);
    @(negedge clk);
    rst_n   = rst_v;
    instr   = i;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    chk({tag, ".ctrl"}, 32'({regdst, regwrite, branch, jump, memread, memtoreg,
                             memwrite, aluop, alusrc}), 32'(exp_ctrl));
    chk({tag, ".aluctrl"}, 32'(aluctrl), 32'(exp_aluctrl));
    chk({tag, ".result"}, alu_result, exp_res);
    chk({tag, ".zero"}, 32'(alu_zero), 32'(exp_zero));
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;

    run("reset_lw", 1'b0, 32'h8D28FFFC, 32'h100, 32'd0, C_NOP, 4'b0000, 32'd0, 1'b0);
    run("lw",       1'b1, 32'h8D28FFFC, 32'h100, 32'd0, C_LW, 4'b0010, 32'h000000FC, 1'b0);
    run("add",      1'b1, 32'h012A4020, 32'd5, 32'd7, C_R, 4'b0010, 32'd12, 1'b0);
    run("sub_eq",   1'b1, 32'h012A4022, 32'd9, 32'd9, C_R, 4'b0110, 32'd0, 1'b1);
    run("slt_neg",  1'b1, 32'h012A402A, 32'hFFFFFFFF, 32'd1, C_R, 4'b0111, 32'd1, 1'b0);
    run("slt_swap", 1'b1, 32'h012A402A, 32'd1, 32'hFFFFFFFF, C_R, 4'b0111, 32'd0, 1'b1);
    run("nor_zero", 1'b1, 32'h012A4027, 32'd0, 32'd0, C_R, 4'b1100, 32'hFFFFFFFF, 1'b0);
    run("and",      1'b1, 32'h012A4024, 32'h0000F0F0, 32'h0000FF00, C_R, 4'b0000, 32'h0000F000, 1'b0);
    run("or",       1'b1, 32'h012A4025, 32'h0000F0F0, 32'h0000FF00, C_R, 4'b0001, 32'h0000FFF0, 1'b0);
    run("bad_funct",1'b1, 32'h012A403F, 32'd5, 32'd7, C_R, 4'b1111, 32'd0, 1'b1);
    run("sub_wrap", 1'b1, 32'h012A4022, 32'd0, 32'd1, C_R, 4'b0110, 32'hFFFFFFFF, 1'b0);
    run("sw",       1'b1, 32'hAD280004, 32'h100, 32'hDEAD, C_SW, 4'b0010, 32'h104, 1'b0);
    run("beq",      1'b1, 32'h112A0003, 32'd3, 32'd3, C_BEQ, 4'b0110, 32'd0, 1'b1);
    run("addi_neg", 1'b1, 32'h2128FFFF, 32'd5, 32'd0, C_ADDI, 4'b0010, 32'd4, 1'b0);
    run("ori_sext", 1'b1, 32'h35288000, 32'd1, 32'd0, C_ORI, 4'b0001, 32'hFFFF8001, 1'b0);
    run("j",        1'b1, 32'h08000010, 32'd1, 32'd2, C_J, 4'b0010, 32'd3, 1'b0);
    run("jal",      1'b1, 32'h0C000010, 32'd1, 32'd2, C_JAL, 4'b0010, 32'd3, 1'b0);
    run("op_3f",    1'b1, 32'hFC000000, 32'd4, 32'd6, C_NOP, 4'b0010, 32'd10, 1'b0);
`ifdef ALU_SHIFT_EN
    run("sll",      1'b1, 32'h00084100, 32'd0, 32'd1, C_R, 4'b1000, 32'h10, 1'b0);
    run("srl",      1'b1, 32'h00084102, 32'd0, 32'h80000000, C_R, 4'b1001, 32'h08000000, 1'b0);
`else
    run("sll_off",  1'b1, 32'h00084100, 32'd0, 32'd1, C_R, 4'b1111, 32'd0, 1'b1);
    run("srl_off",  1'b1, 32'h00084102, 32'd0, 32'h80000000, C_R, 4'b1111, 32'd0, 1'b1);
`endif
    run("reset_mid",1'b0, 32'h012A4020, 32'd5, 32'd7, C_NOP, 4'b0000, 32'd0, 1'b0);
    run("after_rst",1'b1, 32'h012A4020, 32'd5, 32'd7, C_R, 4'b0010, 32'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
